sram_port_arbiter: RTL and testbench
====================================

# sram_port_arbiter

Shares one single-ported synchronous SRAM between the CPU's instruction-fetch port and data (load/store) port. Sits between the `mycpu` core's inst/data SRAM request interfaces and the unified memory. Grants one access per cycle with data-side priority plus an anti-starvation counter for fetch, and routes each 1-cycle-latency response back to its owner.

## Interface

**Parameters**

- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `STARVE_LIMIT`, default 4: maximum number of consecutive data grants while fetch is waiting before fetch is forced through.

**Ports** (clock and reset first)

- `clk`  in  1: clock.
- `reset`  in  1: reset, synchronous, active-high.
- `i_req`  in  1: fetch request.
- `i_addr`  in  ADDR_W: fetch address.
- `i_gnt`  out  1: fetch request accepted this cycle.
- `i_rvalid`  out  1: fetch data valid.
- `i_rdata`  out  DATA_W: fetch data.
- `d_req`  in  1: data request.
- `d_we`  in  1: data write.
- `d_addr`  in  ADDR_W: data address.
- `d_wdata`  in  DATA_W: store data.
- `d_gnt`  out  1: data request accepted this cycle.
- `d_rvalid`  out  1: load data valid, or store acknowledge.
- `d_rdata`  out  DATA_W: load data (don't-care on a store ack).
- `mem_en`  out  1: SRAM access strobe.
- `mem_we`  out  1: SRAM write.
- `mem_addr`  out  ADDR_W: SRAM address.
- `mem_wdata`  out  DATA_W: SRAM write data.
- `mem_rdata`  in  DATA_W: SRAM read data, valid the cycle after `mem_en`.

## Operation

**Grant and access**
- A request is accepted in the cycle where `req` and `gnt` are both high.
- `gnt` depends combinationally on the `req` inputs and on registered state only.
- Requesters hold `req`, `addr`, `we` and `wdata` stable until granted.
- At most one grant per cycle.
- `mem_en`, `mem_we`, `mem_addr` and `mem_wdata` are driven combinationally from the granted requester in the grant cycle.
- When nothing is granted, `mem_en` = 0 and `mem_we` = 0.

**Arbitration**
- Only one request present: that requester is granted.
- Both requests present: data wins unless `starve_cnt` == STARVE_LIMIT, in which case fetch wins.

**`starve_cnt`** (register, 0..STARVE_LIMIT)
- Increments on a data grant while `i_req` is high; saturates at STARVE_LIMIT.
- Clears to 0 on a fetch grant, or in any cycle where `i_req` is low.

**Response routing**
- Register `owner` ∈ {NONE, INST, DATA} records the granted requester each cycle (NONE if no grant).
- Next cycle: `i_rvalid` = (`owner` == INST) and `d_rvalid` = (`owner` == DATA).
- `i_rdata` and `d_rdata` both equal `mem_rdata`.
- Stores also return a `d_rvalid` ack.

**Back-to-back operation**
- A new grant is allowed in the same cycle a response is returned, so sustained throughput is 1 access per cycle.

**Reset**
- `owner` ← NONE and `starve_cnt` ← 0.
- During reset: all `gnt`, `rvalid`, `mem_en` and `mem_we` outputs are 0, regardless of `req`.
- Reset mid-operation drops any in-flight response: no `rvalid` appears in the cycle after reset deasserts.

## Timing

- Grant latency: 0 cycles, same cycle as `req` when uncontested.
- Read/ack latency: `rvalid` exactly 1 cycle after the grant.
- Worst-case fetch wait under continuous data traffic: STARVE_LIMIT cycles, granted in cycle STARVE_LIMIT+1.
- Reset values:
  - `i_gnt` = `d_gnt` = 0.
  - `i_rvalid` = `d_rvalid` = 0.
  - `mem_en` = `mem_we` = 0.
  - `mem_addr` and `mem_wdata` = 0.
- Simultaneous response to A and grant to B in the same cycle: both occur; `owner` updates to B.
- `owner` and `starve_cnt` are the only state. No combinational path exists from `mem_rdata` to any `gnt`.

## Structure

- Shared package `sram_arb_pkg` holds:
  - owner enum `OWN_NONE`/`OWN_INST`/`OWN_DATA` (2-bit);
  - default `STARVE_LIMIT`.
- One sub-module, `sram_arb_pick`: the 2-way priority picker with starvation override. It takes both `req`s plus `starve_cnt` == STARVE_LIMIT and outputs the one-hot grant.
- The top level instantiates the picker, the `owner` and `starve_cnt` registers, the address/data mux and the response demux.

## Test plan

1. Fetch only: `i_req`=1 with `i_addr`=0x1c000000 → `i_gnt`=1 and `mem_en`=1 in the same cycle; next cycle `i_rvalid`=1 and `i_rdata` = memory word.
2. Store then load to 0x100: `d_we`=1 with `d_wdata`=0xdeadbeef, then `d_we`=0 → `d_rvalid` ack after the store; `d_rdata`=0xdeadbeef one cycle after the load grant.
3. Contention: both requests held for 8 cycles, STARVE_LIMIT=4 → grants D,D,D,D,I,D,D,D; `starve_cnt` peaks at 4 and clears after the I grant.
4. Back-to-back alternating requests → one grant every cycle; each `rvalid` is routed to the correct owner with no bubbles.
5. Reset asserted the cycle after a data grant → no `d_rvalid` after reset; all outputs 0 during reset; `starve_cnt`=0 afterwards.
6. Random `req` streams with a scoreboard model → every accepted request receives exactly one `rvalid`, in order, with correct data; no fetch wait exceeds STARVE_LIMIT+1 cycles.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared owner encoding and default starvation limit for the SRAM port arbiter
package sram_arb_pkg;
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INST = 2'd1,
        OWN_DATA = 2'd2
    } owner_t;
    localparam int STARVE_LIMIT_DEF = 4;
endpackage

// File: rtl/sram_arb_pick.sv
// sram_arb_pick: 2-way priority picker, data first unless fetch has starved
module sram_arb_pick
    import sram_arb_pkg::*;
(
    input  logic       i_inst_req,
    input  logic       i_data_req,
    input  logic       i_starved,
    output logic [1:0] o_gnt
);
    // bit 0 grants fetch, bit 1 grants data
    assign o_gnt[0] = i_inst_req && (!i_data_req || i_starved);
    assign o_gnt[1] = i_data_req && !o_gnt[0];
endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-ported SRAM between the fetch and load/store ports
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int CW = $clog2(STARVE_LIMIT + 2);
    localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

    owner_t        r_owner, w_owner_nxt;
    logic [CW-1:0] r_starve, w_starve_nxt;
    logic [1:0]    w_pick;
    logic          w_ig, w_dg;

    sram_arb_pick u_pick (
        .i_inst_req (i_req),
        .i_data_req (d_req),
        .i_starved  (r_starve == LIM),
        .o_gnt      (w_pick)
    );

    always_comb begin
        w_ig         = !reset && w_pick[0];
        w_dg         = !reset && w_pick[1];
        i_gnt        = w_ig;
        d_gnt        = w_dg;
        mem_en       = w_ig || w_dg;
        mem_we       = w_dg && d_we;
        mem_addr     = w_dg ? d_addr : w_ig ? i_addr : '0;
        mem_wdata    = w_dg ? d_wdata : '0;
        w_owner_nxt  = w_dg ? OWN_DATA : w_ig ? OWN_INST : OWN_NONE;
        w_starve_nxt = (!i_req || w_ig) ? '0 : (w_dg && r_starve != LIM) ? r_starve + CW'(1) : r_starve;
        // reset also masks a response still owed from before reset
        i_rvalid     = !reset && r_owner == OWN_INST;
        d_rvalid     = !reset && r_owner == OWN_DATA;
        i_rdata      = mem_rdata;
        d_rdata      = mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner  <= OWN_NONE;
            r_starve <= '0;
        end else begin
            r_owner  <= w_owner_nxt;
            r_starve <= w_starve_nxt;
        end
    end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: table, directed and random checks of the SRAM port arbiter against a reference model
module tb_sram_port_arbiter;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, i_gnt, i_rvalid;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int total = 0;
    int bad   = 0;

    sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'h5a5a_a5a5;
    endfunction

    // behavioural single-ported SRAM, read-first, one cycle read latency
    logic [31:0] sram [logic [31:0]];
    initial mem_rdata = '0;
    always @(posedge clk) begin
        if (mem_en) begin
            mem_rdata <= sram.exists(mem_addr) ? sram[mem_addr] : dflt(mem_addr);
            if (mem_we) sram[mem_addr] = mem_wdata;
        end
    end

    // reference model state: consecutive fetch losses, expected response, shadow memory
    logic [31:0] shadow [logic [31:0]];
    int          losses = 0;
    logic        exp_iv = 0, exp_dv = 0, exp_dload = 0;
    logic [31:0] exp_data = '0;
    logic        last_gi = 0, last_gd = 0;

    function automatic logic [31:0] rd(input logic [31:0] a);
        return shadow.exists(a) ? shadow[a] : dflt(a);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic adv();
        logic egi, egd;
        egi = !reset && i_req && (!d_req || losses == LIMIT);
        egd = !reset && d_req && !egi;
        chk("i_gnt", 64'(i_gnt), 64'(egi));
        chk("d_gnt", 64'(d_gnt), 64'(egd));
        chk("mem_en", 64'(mem_en), 64'(egi || egd));
        chk("mem_we", 64'(mem_we), 64'(egd && d_we));
        if (egi || egd) chk("mem_addr", 64'(mem_addr), 64'(egd ? d_addr : i_addr));
        if (egd && d_we) chk("mem_wdata", 64'(mem_wdata), 64'(d_wdata));
        if (reset) begin
            chk("rst_mem_addr", 64'(mem_addr), 64'd0);
            chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        end
        chk("i_rvalid", 64'(i_rvalid), 64'(!reset && exp_iv));
        chk("d_rvalid", 64'(d_rvalid), 64'(!reset && exp_dv));
        if (!reset && exp_iv) chk("i_rdata", 64'(i_rdata), 64'(exp_data));
        if (!reset && exp_dv && exp_dload) chk("d_rdata", 64'(d_rdata), 64'(exp_data));
        if (reset) begin
            losses = 0;
            exp_iv = 0;
            exp_dv = 0;
        end else begin
            losses    = (i_req && !egi) ? losses + 1 : 0;
            exp_iv    = egi;
            exp_dv    = egd;
            exp_dload = egd && !d_we;
            exp_data  = egi ? rd(i_addr) : rd(d_addr);
            if (egd && d_we) shadow[d_addr] = d_wdata;
        end
        last_gi = egi;
        last_gd = egd;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic ir;
        logic dr;
        logic eig;
        logic edg;
    } vec_t;

    vec_t tbl [12];
    int   iwait;

    initial begin
        tbl[0]  = '{1, 1, 0, 1};
        tbl[1]  = '{1, 1, 0, 1};
        tbl[2]  = '{1, 1, 0, 1};
        tbl[3]  = '{1, 1, 0, 1};
        tbl[4]  = '{1, 1, 1, 0};
        tbl[5]  = '{1, 1, 0, 1};
        tbl[6]  = '{1, 1, 0, 1};
        tbl[7]  = '{1, 1, 0, 1};
        tbl[8]  = '{0, 1, 0, 1};
        tbl[9]  = '{1, 1, 0, 1};
        tbl[10] = '{1, 0, 1, 0};
        tbl[11] = '{0, 0, 0, 0};

        reset = 1; i_req = 1; i_addr = 32'h40; d_req = 1; d_we = 1; d_addr = 32'h44; d_wdata = '0;
        @(posedge clk);
        #1;
        settle();
        chk("reset_i_gnt", 64'(i_gnt), 64'd0);
        chk("reset_d_gnt", 64'(d_gnt), 64'd0);
        chk("reset_mem_en", 64'(mem_en), 64'd0);
        chk("reset_mem_we", 64'(mem_we), 64'd0);
        chk("reset_rvalid", 64'({i_rvalid, d_rvalid}), 64'd0);
        adv();
        adv();
        reset = 0; i_req = 0; d_req = 0; d_we = 0;

        // fetch only
        i_req = 1; i_addr = 32'h1c00_0000;
        settle();
        chk("t1_i_gnt", 64'(i_gnt), 64'd1);
        chk("t1_mem_en", 64'(mem_en), 64'd1);
        chk("t1_mem_addr", 64'(mem_addr), 64'h1c00_0000);
        adv();
        i_req = 0;
        settle();
        chk("t1_i_rvalid", 64'(i_rvalid), 64'd1);
        chk("t1_i_rdata", 64'(i_rdata), 64'(dflt(32'h1c00_0000)));
        adv();

        // store then load
        d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hdead_beef;
        settle();
        chk("t2_st_gnt", 64'(d_gnt), 64'd1);
        chk("t2_mem_we", 64'(mem_we), 64'd1);
        adv();
        d_we = 0; d_wdata = '0;
        settle();
        chk("t2_st_ack", 64'(d_rvalid), 64'd1);
        chk("t2_ld_gnt", 64'(d_gnt), 64'd1);
        adv();
        d_req = 0;
        settle();
        chk("t2_ld_rvalid", 64'(d_rvalid), 64'd1);
        chk("t2_ld_rdata", 64'(d_rdata), 64'hdead_beef);
        adv();

        // contention and starvation override
        i_addr = 32'h200; d_addr = 32'h300; d_we = 0;
        for (int k = 0; k < 12; k++) begin
            i_req = tbl[k].ir;
            d_req = tbl[k].dr;
            settle();
            chk($sformatf("t3_gnt_%0d", k), 64'({i_gnt, d_gnt}), 64'({tbl[k].eig, tbl[k].edg}));
            adv();
        end

        // alternating back-to-back
        for (int k = 0; k < 8; k++) begin
            i_req = (k % 2 == 0); d_req = (k % 2 == 1); d_we = 0;
            i_addr = 32'h1c00_0000 + 32'(4 * k);
            d_addr = 32'h100 + 32'(4 * k);
            settle();
            chk($sformatf("t4_one_gnt_%0d", k), 64'(i_gnt + d_gnt), 64'd1);
            if (k > 0) chk($sformatf("t4_rsp_%0d", k), 64'({i_rvalid, d_rvalid}), 64'(k % 2 == 1 ? 2'b10 : 2'b01));
            adv();
        end

        // reset right after a data grant
        i_req = 1; d_req = 1; d_we = 0; d_addr = 32'h100; i_addr = 32'h1c00_0010;
        settle();
        chk("t5_pre_d_gnt", 64'(d_gnt), 64'd1);
        adv();
        reset = 1;
        settle();
        chk("t5_rst_outs", 64'({i_gnt, d_gnt, i_rvalid, d_rvalid, mem_en, mem_we}), 64'd0);
        adv();
        adv();
        reset = 0;
        settle();
        chk("t5_no_rvalid", 64'({i_rvalid, d_rvalid}), 64'd0);
        for (int k = 0; k < LIMIT + 2; k++) begin
            settle();
            adv();
        end
        i_req = 0; d_req = 0;
        settle();
        adv();

        // random traffic against the model
        iwait = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!i_req || last_gi) begin
                i_req  = $urandom_range(0, 9) < 6;
                i_addr = 32'h1c00_0000 + 32'(4 * $urandom_range(0, 7));
            end
            if (!d_req || last_gd) begin
                d_req   = $urandom_range(0, 9) < 7;
                d_we    = $urandom_range(0, 1) == 1;
                d_addr  = 32'h100 + 32'(4 * $urandom_range(0, 7));
                d_wdata = $urandom;
            end
            reset = $urandom_range(0, 199) == 0;
            settle();
            if (reset || !i_req) iwait = 0;
            else if (i_gnt) begin
                chk("t6_fetch_wait", 64'(iwait <= LIMIT), 64'd1);
                iwait = 0;
            end else iwait++;
            adv();
        end
        reset = 0; i_req = 0; d_req = 0;
        settle();
        adv();
        settle();
        adv();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
